// File: rtl/trng_arbiter.sv
// TRNG byte-stream sequencer: warm-up, fresh-bit refill between samples, repetition-count
// health test and round-robin delivery of each sampled byte to exactly one requester.
module trng_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WARMUP_CYCLES = 64,
    parameter int FILL_CYCLES   = 8,
    parameter int REP_LIMIT     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rnd_byte,
    input  logic [NUM_REQ-1:0] req,
    input  logic               fault_clr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [7:0]         data_out,
    output logic               data_valid,
    output logic               rdy,
    output logic               fault
);

    localparam int MAX_CYC = (WARMUP_CYCLES > FILL_CYCLES) ? WARMUP_CYCLES : FILL_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int REP_W   = $clog2(REP_LIMIT + 1);

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_MAX   = REP_W'(REP_LIMIT);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_WARMUP,
        ST_FILL,
        ST_READY,
        ST_FAULT
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [PTR_W-1:0]   rr_reg, rr_next;
    logic [REP_W-1:0]   rep_cnt_reg, rep_cnt_next;
    logic               have_prev_reg, have_prev_next;
    logic [7:0]         prev_reg, prev_next;
    logic [7:0]         hold_reg, hold_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [7:0]         data_out_reg, data_out_next;
    logic               data_valid_reg, data_valid_next;
    logic               rdy_reg, rdy_next;
    logic               fault_reg, fault_next;

    // Requests rotated so bit 0 is the requester the round-robin pointer favours.
    logic [NUM_REQ-1:0] req_rot;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [PTR_W-1:0]   off;
    logic [PTR_W:0]     sel_sum;
    logic [PTR_W-1:0]   sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [PTR_W:0]   idx_sum;
            logic [PTR_W-1:0] idx;
            assign idx_sum        = {1'b0, rr_reg} + (PTR_W + 1)'(gi);
            assign idx            = (idx_sum >= NUM_REQ_W) ? PTR_W'(idx_sum - NUM_REQ_W)
                                                           : PTR_W'(idx_sum);
            assign req_rot[gi]    = req[idx];
            assign gnt_onehot[gi] = (sel == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = PTR_W'(i);
            end
        end
    end

    assign sel_sum = {1'b0, rr_reg} + {1'b0, off};
    assign sel     = (sel_sum >= NUM_REQ_W) ? PTR_W'(sel_sum - NUM_REQ_W) : PTR_W'(sel_sum);

    logic             same_byte;
    logic [REP_W-1:0] rep_new;
    logic             health_fail;

    assign same_byte   = have_prev_reg && (rnd_byte == prev_reg);
    assign rep_new     = same_byte ? rep_cnt_reg + 1'b1 : REP_W'(1);
    assign health_fail = (rep_new == REP_MAX);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        rr_next         = rr_reg;
        rep_cnt_next    = rep_cnt_reg;
        have_prev_next  = have_prev_reg;
        prev_next       = prev_reg;
        hold_next       = hold_reg;
        gnt_next        = '0;
        data_out_next   = 8'h00;
        data_valid_next = 1'b0;

        case (state_reg)
            ST_WARMUP: begin
                if (cnt_reg == WARM_LAST) begin
                    state_next = ST_FILL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_FILL: begin
                if (cnt_reg == FILL_LAST) begin
                    cnt_next       = '0;
                    hold_next      = rnd_byte;
                    prev_next      = rnd_byte;
                    have_prev_next = 1'b1;
                    rep_cnt_next   = rep_new;
                    state_next     = health_fail ? ST_FAULT : ST_READY;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_READY: begin
                if (|req) begin
                    gnt_next        = gnt_onehot;
                    data_valid_next = 1'b1;
                    data_out_next   = hold_reg;
                    rr_next         = (sel == PTR_LAST) ? '0 : sel + 1'b1;
                    cnt_next        = '0;
                    state_next      = ST_FILL;
                end
            end
            ST_FAULT: begin
                // The pointer survives a clear so fairness carries across the fault.
                if (fault_clr) begin
                    state_next     = ST_WARMUP;
                    cnt_next       = '0;
                    rep_cnt_next   = '0;
                    have_prev_next = 1'b0;
                    prev_next      = 8'h00;
                end
            end
            default: begin
                state_next = ST_WARMUP;
                cnt_next   = '0;
            end
        endcase

        rdy_next   = (state_next == ST_READY);
        fault_next = (state_next == ST_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_WARMUP;
            cnt_reg        <= '0;
            rr_reg         <= '0;
            rep_cnt_reg    <= '0;
            have_prev_reg  <= 1'b0;
            prev_reg       <= 8'h00;
            hold_reg       <= 8'h00;
            gnt_reg        <= '0;
            data_out_reg   <= 8'h00;
            data_valid_reg <= 1'b0;
            rdy_reg        <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            rr_reg         <= rr_next;
            rep_cnt_reg    <= rep_cnt_next;
            have_prev_reg  <= have_prev_next;
            prev_reg       <= prev_next;
            hold_reg       <= hold_next;
            gnt_reg        <= gnt_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            rdy_reg        <= rdy_next;
            fault_reg      <= fault_next;
        end
    end

    assign gnt        = gnt_reg;
    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign rdy        = rdy_reg;
    assign fault      = fault_reg;

endmodule

// File: tb/tb_trng_arbiter.sv
// Directed bench for trng_arbiter: expected grants are queued with their due edge number
// and checked against every data_valid pulse the design produces.
module tb_trng_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rnd_byte = 8'h00;
    logic [3:0] req = 4'b0000;
    logic       fault_clr = 1'b0;
    logic [3:0] gnt;
    logic [7:0] data_out;
    logic       data_valid;
    logic       rdy;
    logic       fault;

    trng_arbiter #(
        .NUM_REQ      (4),
        .WARMUP_CYCLES(64),
        .FILL_CYCLES  (8),
        .REP_LIMIT    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rnd_byte  (rnd_byte),
        .req       (req),
        .fault_clr (fault_clr),
        .gnt       (gnt),
        .data_out  (data_out),
        .data_valid(data_valid),
        .rdy       (rdy),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    bit   inc_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [3:0] g, input logic [7:0] d);
        exp_t e;
        e.cyc  = c;
        e.gnt  = g;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock edge; in incrementing mode the byte sampled at edge n is n[7:0].
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (inc_mode) rnd_byte = 8'(cyc + 1);
    endtask

    task automatic monitor();
        exp_t e;
        if (data_valid === 1'b1) begin
            check("grant_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("grant edge=%0d gnt=%b data=%02h", cyc, gnt, data_out);
                check("grant_edge", cyc, e.cyc);
                check("grant_vec", 32'(gnt), 32'(e.gnt));
                check("grant_data", 32'(data_out), 32'(e.data));
            end
        end else if (gnt !== 4'b0000 || data_out !== 8'h00) begin
            check("idle_outputs", {20'd0, gnt, data_out}, 32'd0);
        end
    endtask

    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            monitor();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_outputs", {19'd0, gnt, data_out, data_valid, rdy, fault}, 32'd0);
        reset = 1'b0;
        cyc = 0;
        if (inc_mode) rnd_byte = 8'd1;
    endtask

    initial begin
        int bad;

        // Latency: first grant one edge after the 72-edge warm-up plus fill.
        inc_mode = 1'b0;
        rnd_byte = 8'h3C;
        req = 4'b0001;
        do_reset();
        run_edges(71);
        check("rdy_before_sample", 32'(rdy), 32'd0);
        run_edges(1);
        check("rdy_after_sample", 32'(rdy), 32'd1);
        push_exp(73, 4'b0001, 8'h3C);
        run_edges(1);
        req = 4'b0000;
        run_edges(15);
        check("latency_drained", 32'(exp_q.size()), 32'd0);

        // Round-robin with all requesters held and a fresh byte every edge.
        inc_mode = 1'b1;
        req = 4'b1111;
        do_reset();
        for (int k = 0; k < 5; k++) push_exp(73 + 9 * k, 4'(1 << (k % 4)), 8'(72 + 9 * k));
        run_edges(112);
        req = 4'b0000;
        run_edges(20);
        check("rr_drained", 32'(exp_q.size()), 32'd0);

        // Fairness with gaps in the request vector.
        req = 4'b0101;
        do_reset();
        for (int k = 0; k < 4; k++) push_exp(73 + 9 * k, (k % 2 == 0) ? 4'b0001 : 4'b0100, 8'(72 + 9 * k));
        run_edges(100);
        req = 4'b0000;
        run_edges(20);
        check("skip_drained", 32'(exp_q.size()), 32'd0);

        // Health fault on a stuck source, then recovery through fault_clr.
        inc_mode = 1'b0;
        rnd_byte = 8'hA5;
        req = 4'b0001;
        do_reset();
        push_exp(73, 4'b0001, 8'hA5);
        push_exp(82, 4'b0001, 8'hA5);
        push_exp(91, 4'b0001, 8'hA5);
        run_edges(98);
        check("fault_before_4th", 32'(fault), 32'd0);
        run_edges(1);
        check("fault_after_4th", 32'(fault), 32'd1);
        check("rdy_in_fault", 32'(rdy), 32'd0);
        run_edges(30);
        check("fault_sticky", 32'(fault), 32'd1);
        fault_clr = 1'b1;
        run_edges(1);
        fault_clr = 1'b0;
        check("fault_cleared", 32'(fault), 32'd0);
        push_exp(203, 4'b0001, 8'hA5);
        run_edges(73);
        req = 4'b0000;
        run_edges(5);
        check("health_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset landing in the grant cycle.
        rnd_byte = 8'h3C;
        req = 4'b0001;
        do_reset();
        push_exp(73, 4'b0001, 8'h3C);
        run_edges(73);
        check("grant_before_reset", 32'(data_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_drop", {20'd0, gnt, data_out}, 32'd0);
        check("async_reset_valid", 32'(data_valid), 32'd0);
        do_reset();
        push_exp(73, 4'b0001, 8'h3C);
        run_edges(80);
        req = 4'b0000;
        check("rereset_drained", 32'(exp_q.size()), 32'd0);

        // Idle hold: the sampled byte survives while the source keeps changing.
        inc_mode = 1'b1;
        req = 4'b0000;
        do_reset();
        run_edges(72);
        check("idle_rdy", 32'(rdy), 32'd1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            fault_clr = (i == 50);
            tick();
            monitor();
            if (data_out !== 8'h00 || rdy !== 1'b1) bad++;
        end
        fault_clr = 1'b0;
        check("idle_quiet_cycles", bad, 0);
        check("idle_no_fault", 32'(fault), 32'd0);
        req = 4'b0001;
        push_exp(173, 4'b0001, 8'h48);
        run_edges(1);
        req = 4'b0000;
        run_edges(12);
        check("idle_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
